if_fetch_unit: RTL and testbench

//  IF-stage fetch engine: owns the PC, issues word fetches to instruction memory over a

---
 rtl/if_pkg.sv | 10 +
 rtl/if_perf_cnt.sv | 38 +++
 rtl/if_fetch_unit.sv | 92 +++++++++
 tb/tb_if_fetch_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// if_pkg: fetch-unit state encoding, reset PC default, bubble word and PC increment
package if_pkg;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} if_state_t;

    localparam logic [31:0] IF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/if_perf_cnt.sv
// if_perf_cnt: three wrapping 32-bit event counters (fetched, bubble, squash)
// Ports: clk, reset (sync, active-high); inc_* event strobes; perf_* counter values.
module if_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc_fetched,
    input  logic        inc_bubble,
    input  logic        inc_squash,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_squash
);

    logic [31:0] fetched_q, fetched_d, bubble_q, bubble_d, squash_q, squash_d;

    always_comb begin
        fetched_d = fetched_q + {31'd0, inc_fetched};
        bubble_d  = bubble_q + {31'd0, inc_bubble};
        squash_d  = squash_q + {31'd0, inc_squash};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            bubble_q  <= '0;
            squash_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            bubble_q  <= bubble_d;
            squash_q  <= squash_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubble  = bubble_q;
    assign perf_squash  = squash_q;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage fetch engine owning the PC, one outstanding imem request, hold buffer
// Ports: clk, reset (sync, active-high); stallF/redirect/redirect_pc from hazard/EX;
//        imem_req_* valid/ready request, imem_rsp_* response; instrF/PCplusF/instr_validF to IF/ID.
// IF_PERF_CNT_EN adds perf_fetched/perf_bubble/perf_squash counter outputs.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = IF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instrF,
    output logic [31:0] PCplusF,
    output logic        instr_validF
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_squash
`endif
);

    if_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_buf_q, instr_buf_d, bufpc_q, bufpc_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_buf_d = instr_buf_q;
        bufpc_d     = bufpc_q;
        case (state_q)
            S_REQ:  state_d = imem_req_ready ? (redirect ? S_DROP : S_WAIT) : S_REQ;
            S_WAIT: begin
                if (imem_rsp_valid && !redirect) begin
                    state_d     = S_HOLD;
                    instr_buf_d = imem_rsp_data;
                    bufpc_d     = pc_q;
                    pc_d        = pc_q + PC_STEP;
                end else if (redirect) begin
                    state_d = imem_rsp_valid ? S_REQ : S_DROP;
                end
            end
            S_HOLD: state_d = (redirect || !stallF) ? S_REQ : S_HOLD;
            // A stale response arriving together with a redirect is still the one
            // we were waiting for, so the new target can be requested right away.
            default: state_d = imem_rsp_valid ? S_REQ : S_DROP;
        endcase
        if (redirect) pc_d = redirect_pc & ~32'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC & ~32'd3;
            instr_buf_q <= '0;
            bufpc_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_buf_q <= instr_buf_d;
            bufpc_q     <= bufpc_d;
        end
    end

    assign imem_req_valid = state_q == S_REQ;
    assign imem_req_addr  = pc_q;
    assign instr_validF   = state_q == S_HOLD;
    assign instrF         = instr_validF ? instr_buf_q : NOP_INSTR;
    assign PCplusF        = instr_validF ? bufpc_q + PC_STEP : 32'd0;

`ifdef IF_PERF_CNT_EN
    if_perf_cnt u_perf (
        .clk         (clk),
        .reset       (reset),
        .inc_fetched (instr_validF && !stallF && !redirect),
        .inc_bubble  (!stallF && !instr_validF),
        .inc_squash  (imem_rsp_valid && (state_q == S_DROP || (state_q == S_WAIT && redirect))),
        .perf_fetched(perf_fetched),
        .perf_bubble (perf_bubble),
        .perf_squash (perf_squash)
    );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset, stallF, redirect, imem_req_ready, imem_rsp_valid;
    logic [31:0] redirect_pc, imem_rsp_data;
    logic        imem_req_valid, instr_validF;
    logic [31:0] imem_req_addr, instrF, PCplusF;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_bubble, perf_squash;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stallF        (stallF),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instrF        (instrF),
        .PCplusF       (PCplusF),
        .instr_validF  (instr_validF)
`ifdef IF_PERF_CNT_EN
       ,.perf_fetched  (perf_fetched),
        .perf_bubble   (perf_bubble),
        .perf_squash   (perf_squash)
`endif
    );

    always @(posedge clk)
        if (!reset)
            assert (!(imem_rsp_valid && (imem_req_valid || instr_validF)))
                else $error("protocol violation: rsp_valid outside wait/drop");

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stallF = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        tick(); tick();
        reset = 1'b0;
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL reset_req_valid got=%b want=1", imem_req_valid); end
        total++; if (imem_req_addr !== 32'h3000) begin bad++; $display("FAIL reset_addr got=%h want=00003000", imem_req_addr); end
        total++; if (instrF !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", instrF); end
        total++; if (PCplusF !== 32'h0) begin bad++; $display("FAIL reset_pcplus got=%h want=0", PCplusF); end
        total++; if (instr_validF !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_validF); end
    endtask

    task automatic test_fetch();
        tick();
        total++; if (imem_req_valid !== 1'b0 || instr_validF !== 1'b0) begin bad++; $display("FAIL fetch_wait got=%b%b want=00", imem_req_valid, instr_validF); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hA000_3000;
        tick();
        imem_rsp_valid = 1'b0;
        total++; if (instrF !== 32'hA000_3000) begin bad++; $display("FAIL fetch_instr got=%h want=a0003000", instrF); end
        total++; if (PCplusF !== 32'h3004) begin bad++; $display("FAIL fetch_pcplus got=%h want=00003004", PCplusF); end
        total++; if (instr_validF !== 1'b1) begin bad++; $display("FAIL fetch_valid got=%b want=1", instr_validF); end
        tick();
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3004) begin bad++; $display("FAIL fetch_next got=%b/%h want=1/00003004", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_stall();
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hB000_3004;
        tick();
        imem_rsp_valid = 1'b0; stallF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (instrF !== 32'hB000_3004 || PCplusF !== 32'h3008 || imem_req_valid !== 1'b0) begin
                bad++; $display("FAIL stall_hold[%0d] got=%h/%h/%b want=b0003004/00003008/0", i, instrF, PCplusF, imem_req_valid);
            end
        end
        stallF = 1'b0;
        tick();
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3008) begin bad++; $display("FAIL stall_release got=%b/%h want=1/00003008", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_redirect_wait();
        tick();
        redirect = 1'b1; redirect_pc = 32'h3102;
        tick();
        redirect = 1'b0;
        total++; if (imem_req_valid !== 1'b0 || instr_validF !== 1'b0) begin bad++; $display("FAIL drop_enter got=%b%b want=00", imem_req_valid, instr_validF); end
        tick();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL drop_wait got=%b want=0", imem_req_valid); end
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3100 || instr_validF !== 1'b0) begin
            bad++; $display("FAIL drop_exit got=%b/%h/%b want=1/00003100/0", imem_req_valid, imem_req_addr, instr_validF);
        end
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hC000_3100;
        tick();
        imem_rsp_valid = 1'b0;
        total++; if (instrF !== 32'hC000_3100 || PCplusF !== 32'h3104) begin bad++; $display("FAIL redirect_target got=%h/%h want=c0003100/00003104", instrF, PCplusF); end
        tick();
    endtask

    task automatic test_redirect_rsp_same();
        tick();
        redirect = 1'b1; redirect_pc = 32'h3100;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0001;
        tick();
        redirect = 1'b0; imem_rsp_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3100 || instr_validF !== 1'b0) begin
            bad++; $display("FAIL redirect_rsp got=%b/%h/%b want=1/00003100/0", imem_req_valid, imem_req_addr, instr_validF);
        end
    endtask

    task automatic test_ready_low();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3100) begin
                bad++; $display("FAIL ready_hold[%0d] got=%b/%h want=1/00003100", i, imem_req_valid, imem_req_addr);
            end
        end
        redirect = 1'b1; redirect_pc = 32'h3200;
        tick();
        redirect = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3200) begin bad++; $display("FAIL ready_redirect got=%b/%h want=1/00003200", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hD000_3200;
        tick();
        imem_rsp_valid = 1'b0;
        total++; if (instrF !== 32'hD000_3200 || PCplusF !== 32'h3204 || instr_validF !== 1'b1) begin
            bad++; $display("FAIL ready_fetch got=%h/%h/%b want=d0003200/00003204/1", instrF, PCplusF, instr_validF);
        end
        tick();
    endtask

    task automatic test_wrap();
        imem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        total++; if (imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h want=fffffffc", imem_req_addr); end
        imem_req_ready = 1'b1;
        tick();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hE000_FFFC;
        tick();
        imem_rsp_valid = 1'b0;
        total++; if (instrF !== 32'hE000_FFFC || PCplusF !== 32'h0) begin bad++; $display("FAIL wrap_pcplus got=%h/%h want=e000fffc/00000000", instrF, PCplusF); end
        tick();
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%b/%h want=1/00000000", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_reset_wait();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h3000) begin bad++; $display("FAIL rst_wait_req got=%b/%h want=1/00003000", imem_req_valid, imem_req_addr); end
        total++; if (instr_validF !== 1'b0 || instrF !== 32'h0) begin bad++; $display("FAIL rst_wait_out got=%b/%h want=0/00000000", instr_validF, instrF); end
`ifdef IF_PERF_CNT_EN
        total++; if (perf_fetched !== 32'h0 || perf_bubble !== 32'h0 || perf_squash !== 32'h0) begin
            bad++; $display("FAIL rst_perf got=%h/%h/%h want=0/0/0", perf_fetched, perf_bubble, perf_squash);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp_same();
        test_ready_low();
        test_wrap();
        test_reset_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
